// File: rtl/u_pe_ctrl_if.sv
// Bundle between u_pe_ctrl, the layer sequencer, the IMap/weight/result buffers
// and the PE column. slave = scheduler side, master = surrounding system side.
interface u_pe_ctrl_if #(
  parameter int unsigned PE_NUM = 8,
  parameter int unsigned ADDR_W = 14
);
  logic                  Start;
  logic                  Clear;
  logic [10:0]           Calcycle;
  logic [9:0]            OutLen;
  logic                  IMapRdEn;
  logic [ADDR_W-1:0]     IMapRdAddr;
  logic [7:0]            IMapRdData;
  logic                  WtRdEn;
  logic [10:0]           WtRdAddr;
  logic [8*PE_NUM-1:0]   WtRdData;
  logic [10:0]           PE_Calcycle;
  logic [7:0]            PE_IMap;
  logic                  PE_IMapVld;
  logic [8*PE_NUM-1:0]   PE_Weight;
  logic [PE_NUM-1:0]     PE_WeightVld;
  logic [15:0]           PE_OMap;
  logic                  PE_OMapVld;
  logic                  ResWrEn;
  logic [ADDR_W-1:0]     ResWrAddr;
  logic [15:0]           ResWrData;
  logic                  Busy;
  logic                  Done;

  modport slave (
    input  Start, Clear, Calcycle, OutLen, IMapRdData, WtRdData, PE_OMap, PE_OMapVld,
    output IMapRdEn, IMapRdAddr, WtRdEn, WtRdAddr, PE_Calcycle, PE_IMap, PE_IMapVld,
           PE_Weight, PE_WeightVld, ResWrEn, ResWrAddr, ResWrData, Busy, Done
  );

  modport master (
    output Start, Clear, Calcycle, OutLen, IMapRdData, WtRdData, PE_OMap, PE_OMapVld,
    input  IMapRdEn, IMapRdAddr, WtRdEn, WtRdAddr, PE_Calcycle, PE_IMap, PE_IMapVld,
           PE_Weight, PE_WeightVld, ResWrEn, ResWrAddr, ResWrData, Busy, Done
  );
endinterface

// File: rtl/u_pe_ctrl.sv
// Systolic-column scheduler: issues IMap/weight reads, skews weights per PE row,
// collects results into the result buffer. Define PE_CTRL_RELU_EN for ReLU on write.
module u_pe_ctrl #(
  parameter int unsigned PE_NUM = 8,
  parameter int unsigned ADDR_W = 14
) (
  input  logic         clk_cal,
  input  logic         rst_cal_n,
  u_pe_ctrl_if.slave   bus
);

  localparam int unsigned CAL_W  = 11;
  localparam int unsigned LEN_W  = 10;
  localparam int unsigned CNT_W  = 14;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e              state_q, state_d;
  logic [CAL_W-1:0]    cal_q, cal_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    exp_q, exp_d;
  logic [CAL_W-1:0]    k_q, k_d;
  logic [LEN_W-1:0]    p_q, p_d;
  logic [ADDR_W-1:0]   lin_q, lin_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
  logic                res_wr_en_q, res_wr_en_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic [PE_NUM-1:0]   vld_q, vld_d;
  logic [RES_W-1:0]    res_fmt;

`ifdef PE_CTRL_RELU_EN
  assign res_fmt = bus.PE_OMap[RES_W-1] ? '0 : bus.PE_OMap;
`else
  assign res_fmt = bus.PE_OMap;
`endif

  // Next-state, read sequencing and result collection
  always_comb begin
    state_d     = state_q;
    cal_d       = cal_q;
    len_d       = len_q;
    exp_d       = exp_q;
    k_d         = k_q;
    p_d         = p_q;
    lin_d       = lin_q;
    rd_en_d     = 1'b0;
    done_d      = 1'b0;
    res_cnt_d   = res_cnt_q;
    res_wr_en_d = 1'b0;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;

    if (state_q != IDLE && bus.PE_OMapVld && res_cnt_q != exp_q) begin
      res_wr_en_d = 1'b1;
      res_addr_d  = ADDR_W'(res_cnt_q);
      res_data_d  = res_fmt;
      res_cnt_d   = res_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          cal_d      = bus.Calcycle;
          len_d      = bus.OutLen;
          exp_d      = CNT_W'(32'(bus.OutLen) * PE_NUM);
          k_d        = '0;
          p_d        = '0;
          lin_d      = '0;
          res_cnt_d  = '0;
          res_addr_d = '0;
          if (bus.Calcycle == '0 || bus.OutLen == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            rd_en_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        // k_q/p_q/lin_q describe the read currently on the bus
        if (k_q == cal_q - CAL_W'(1) && p_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          lin_d   = lin_q + ADDR_W'(1);
          if (k_q == cal_q - CAL_W'(1)) begin
            k_d = '0;
            p_d = p_q + LEN_W'(1);
          end else begin
            k_d = k_q + CAL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (res_cnt_d == exp_q) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.Clear) begin
      state_d     = IDLE;
      k_d         = '0;
      p_d         = '0;
      lin_d       = '0;
      rd_en_d     = 1'b0;
      done_d      = 1'b0;
      res_cnt_d   = '0;
      res_wr_en_d = 1'b0;
      res_addr_d  = '0;
      res_data_d  = '0;
    end

    busy_d = (state_d != IDLE);
    vld_d  = bus.Clear ? '0 : PE_NUM'({vld_q, rd_en_q});
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      state_q     <= IDLE;
      cal_q       <= '0;
      len_q       <= '0;
      exp_q       <= '0;
      k_q         <= '0;
      p_q         <= '0;
      lin_q       <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_cnt_q   <= '0;
      res_wr_en_q <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      cal_q       <= cal_d;
      len_q       <= len_d;
      exp_q       <= exp_d;
      k_q         <= k_d;
      p_q         <= p_d;
      lin_q       <= lin_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_cnt_q   <= res_cnt_d;
      res_wr_en_q <= res_wr_en_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      vld_q       <= vld_d;
    end
  end

  // Weight byte i is delayed i cycles so it meets the IMap after i hops
  assign bus.PE_Weight[BYTE_W-1:0] = vld_q[0] ? bus.WtRdData[BYTE_W-1:0] : '0;

  for (genvar i = 1; i < PE_NUM; i++) begin : g_skew
    logic [BYTE_W*i-1:0] sk_q, sk_d;

    always_comb begin
      sk_d = bus.Clear ? '0 : (BYTE_W*i)'({sk_q, bus.WtRdData[BYTE_W*i +: BYTE_W]});
    end

    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) sk_q <= '0;
      else            sk_q <= sk_d;
    end

    assign bus.PE_Weight[BYTE_W*i +: BYTE_W] = vld_q[i] ? sk_q[BYTE_W*i-1 -: BYTE_W] : '0;
  end

  assign bus.IMapRdEn     = rd_en_q;
  assign bus.IMapRdAddr   = lin_q;
  assign bus.WtRdEn       = rd_en_q;
  assign bus.WtRdAddr     = k_q;
  assign bus.PE_Calcycle  = cal_q;
  assign bus.PE_IMapVld   = vld_q[0];
  assign bus.PE_IMap      = vld_q[0] ? bus.IMapRdData : '0;
  assign bus.PE_WeightVld = vld_q;
  assign bus.ResWrEn      = res_wr_en_q;
  assign bus.ResWrAddr    = res_addr_q;
  assign bus.ResWrData    = res_data_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;

endmodule

// File: tb/tb_u_pe_ctrl.sv
// Directed self-checking bench for u_pe_ctrl with a behavioural PE column model.
module tb_u_pe_ctrl;
  localparam int unsigned PE_NUM = 8;
  localparam int unsigned ADDR_W = 14;

  logic clk_cal = 1'b0;
  logic rst_cal_n;
  always #5 clk_cal = ~clk_cal;

  u_pe_ctrl_if #(.PE_NUM(PE_NUM), .ADDR_W(ADDR_W)) bus ();
  u_pe_ctrl #(.PE_NUM(PE_NUM), .ADDR_W(ADDR_W)) dut (
    .clk_cal   (clk_cal),
    .rst_cal_n (rst_cal_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic        model_en;
  logic        d_vld, m_vld;
  logic [15:0] d_omap, m_omap;
  logic [10:0] m_cal;
  assign bus.PE_OMapVld = model_en ? m_vld : d_vld;
  assign bus.PE_OMap    = model_en ? m_omap : d_omap;

  // PE column model: PE i sees the IMap i cycles late, emits after m_cal MACs
  logic [15:0] res_fifo[$];
  logic [7:0]  hist[PE_NUM];
  logic [15:0] acc[PE_NUM];
  int          cnt[PE_NUM];
  logic [7:0]  im;

  always @(posedge clk_cal) begin
    if (!model_en) begin
      res_fifo.delete();
      for (int i = 0; i < PE_NUM; i++) begin
        hist[i] = 8'h00; acc[i] = 16'h0; cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (bus.PE_WeightVld[i]) begin
          if (i == 0) im = bus.PE_IMap;
          else        im = hist[i-1];
          acc[i] = acc[i] + 16'(bus.PE_Weight[8*i +: 8]) * 16'(im);
          cnt[i] = cnt[i] + 1;
          if (cnt[i] == int'(m_cal)) begin
            res_fifo.push_back(acc[i]);
            acc[i] = 16'h0;
            cnt[i] = 0;
          end
        end
      end
      for (int i = PE_NUM - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.PE_IMap;
    end
  end

  always @(negedge clk_cal) begin
    if (model_en && res_fifo.size() > 0) begin
      m_vld  = 1'b1;
      m_omap = res_fifo.pop_front();
    end else begin
      m_vld  = 1'b0;
      m_omap = 16'h0;
    end
  end

  task automatic cyc();
    @(negedge clk_cal);
  endtask

  // Start sampled at the next rising edge; returns at the falling edge after it
  task automatic start_job(input logic [10:0] c, input logic [9:0] l);
    bus.Calcycle = c;
    bus.OutLen   = l;
    m_cal        = c;
    bus.Start    = 1'b1;
    cyc();
    bus.Start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_cal_n = 1'b0;
    cyc();
    n_cmp++; if ({bus.Busy, bus.Done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b required 00", {bus.Busy, bus.Done}); end
    n_cmp++; if ({bus.IMapRdEn, bus.WtRdEn, bus.PE_IMapVld, bus.ResWrEn} !== 4'b0000) begin n_err++; $display("FAIL reset_enables: got %b required 0000", {bus.IMapRdEn, bus.WtRdEn, bus.PE_IMapVld, bus.ResWrEn}); end
    n_cmp++; if (bus.PE_WeightVld !== '0) begin n_err++; $display("FAIL reset_wvld: got %h required 0", bus.PE_WeightVld); end
    n_cmp++; if ({bus.IMapRdAddr, bus.WtRdAddr, bus.ResWrAddr} !== '0) begin n_err++; $display("FAIL reset_addr: got %h/%h/%h required 0", bus.IMapRdAddr, bus.WtRdAddr, bus.ResWrAddr); end
    n_cmp++; if ({bus.PE_Calcycle, bus.ResWrData, bus.PE_IMap, bus.PE_Weight} !== '0) begin n_err++; $display("FAIL reset_data: got nonzero data outputs"); end
    rst_cal_n = 1'b1;
    cyc();
  endtask

  task automatic test_addr_seq();
    logic [7:0] b;
    bus.IMapRdData = 8'h5A;
    bus.WtRdData   = {PE_NUM{8'hEE}};
    start_job(11'd3, 10'd2);
    bus.WtRdData   = {PE_NUM{8'h10}};
    for (int j = 0; j < 12; j++) begin
      n_cmp++; if (bus.IMapRdEn !== (j < 6)) begin n_err++; $display("FAIL seq_rden[%0d]: got %b required %b", j, bus.IMapRdEn, (j < 6)); end
      if (j < 6) begin
        n_cmp++; if (bus.IMapRdAddr !== ADDR_W'(j)) begin n_err++; $display("FAIL seq_imap_addr[%0d]: got %0d required %0d", j, bus.IMapRdAddr, j); end
        n_cmp++; if (bus.WtRdAddr !== 11'(j % 3)) begin n_err++; $display("FAIL seq_wt_addr[%0d]: got %0d required %0d", j, bus.WtRdAddr, j % 3); end
      end
      n_cmp++; if (bus.PE_WeightVld[7] !== (j >= 8)) begin n_err++; $display("FAIL seq_wvld7[%0d]: got %b required %b", j, bus.PE_WeightVld[7], (j >= 8)); end
      n_cmp++; if (bus.PE_IMapVld !== (j >= 1 && j <= 6)) begin n_err++; $display("FAIL seq_ivld[%0d]: got %b", j, bus.PE_IMapVld); end
      if (j == 1) begin
        n_cmp++; if (bus.PE_IMap !== 8'h5A) begin n_err++; $display("FAIL seq_imap: got %h required 5a", bus.PE_IMap); end
        b = bus.PE_Weight[7:0];
        n_cmp++; if (b !== 8'h11) begin n_err++; $display("FAIL seq_w0: got %h required 11", b); end
      end
      if (j == 4) begin
        b = bus.PE_Weight[31:24];
        n_cmp++; if (b !== 8'h11) begin n_err++; $display("FAIL seq_w3: got %h required 11", b); end
      end
      if (j == 7) begin
        b = bus.PE_Weight[63:56];
        n_cmp++; if (b !== 8'h00) begin n_err++; $display("FAIL seq_w7_gated: got %h required 00", b); end
      end
      if (j == 8) begin
        b = bus.PE_Weight[63:56];
        n_cmp++; if (b !== 8'h11) begin n_err++; $display("FAIL seq_w7: got %h required 11", b); end
      end
      @(posedge clk_cal);
      #1 bus.WtRdData = {PE_NUM{8'(8'h11 + j)}};
      cyc();
    end
    // In DRAIN (no results arrive): a new Start must be ignored
    start_job(11'd7, 10'd1);
    cyc();
    n_cmp++; if (bus.IMapRdEn !== 1'b0) begin n_err++; $display("FAIL drain_start_rden: got %b required 0", bus.IMapRdEn); end
    n_cmp++; if (bus.PE_Calcycle !== 11'd3) begin n_err++; $display("FAIL drain_start_cal: got %0d required 3", bus.PE_Calcycle); end
    n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b required 1", bus.Busy); end
    bus.Clear = 1'b1; cyc(); bus.Clear = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL drain_clear_busy: got %b required 0", bus.Busy); end
  endtask

  task automatic test_model();
    int wr_cnt, done_cnt, done_at, last_wr;
    wr_cnt = 0; done_cnt = 0; done_at = -1; last_wr = -1;
    model_en = 1'b1;
    bus.IMapRdData = 8'h01;
    bus.WtRdData   = {PE_NUM{8'h01}};
    cyc();
    start_job(11'd9, 10'd4);
    for (int j = 0; j < 300; j++) begin
      if (bus.ResWrEn) begin
        n_cmp++; if (bus.ResWrAddr !== ADDR_W'(wr_cnt)) begin n_err++; $display("FAIL model_addr[%0d]: got %0d required %0d", wr_cnt, bus.ResWrAddr, wr_cnt); end
        n_cmp++; if (bus.ResWrData !== 16'd9) begin n_err++; $display("FAIL model_data[%0d]: got %0d required 9", wr_cnt, bus.ResWrData); end
        wr_cnt++; last_wr = j;
      end
      if (bus.Done) begin done_cnt++; done_at = j; end
      if (done_cnt > 0 && j > done_at + 5) break;
      cyc();
    end
    n_cmp++; if (wr_cnt !== 32) begin n_err++; $display("FAIL model_writes: got %0d required 32", wr_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL model_done_pulses: got %0d required 1", done_cnt); end
    n_cmp++; if (done_at !== last_wr + 1) begin n_err++; $display("FAIL model_done_time: got %0d required %0d", done_at, last_wr + 1); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL model_busy_end: got %b required 0", bus.Busy); end
    model_en = 1'b0;
    cyc();
  endtask

  task automatic test_zero_len();
    start_job(11'd5, 10'd0);
    n_cmp++; if ({bus.Busy, bus.Done, bus.IMapRdEn} !== 3'b100) begin n_err++; $display("FAIL zero_s0: got %b required 100", {bus.Busy, bus.Done, bus.IMapRdEn}); end
    cyc();
    n_cmp++; if ({bus.Busy, bus.Done, bus.IMapRdEn} !== 3'b010) begin n_err++; $display("FAIL zero_s1: got %b required 010", {bus.Busy, bus.Done, bus.IMapRdEn}); end
    cyc();
    n_cmp++; if ({bus.Busy, bus.Done, bus.ResWrEn} !== 3'b000) begin n_err++; $display("FAIL zero_s2: got %b required 000", {bus.Busy, bus.Done, bus.ResWrEn}); end
  endtask

  task automatic test_clear();
    start_job(11'd3, 10'd3);
    cyc(); cyc(); cyc();
    n_cmp++; if (bus.IMapRdAddr !== ADDR_W'(3)) begin n_err++; $display("FAIL clr_pos1_addr: got %0d required 3", bus.IMapRdAddr); end
    bus.Clear = 1'b1; cyc(); bus.Clear = 1'b0;
    n_cmp++; if ({bus.IMapRdEn, bus.PE_IMapVld, bus.Busy} !== 3'b000) begin n_err++; $display("FAIL clr_flags: got %b required 000", {bus.IMapRdEn, bus.PE_IMapVld, bus.Busy}); end
    n_cmp++; if (bus.PE_WeightVld !== '0) begin n_err++; $display("FAIL clr_wvld: got %h required 0", bus.PE_WeightVld); end
    bus.Clear = 1'b1; bus.Start = 1'b1; cyc(); bus.Clear = 1'b0; bus.Start = 1'b0;
    n_cmp++; if ({bus.Busy, bus.IMapRdEn} !== 2'b00) begin n_err++; $display("FAIL clr_beats_start: got %b required 00", {bus.Busy, bus.IMapRdEn}); end
    start_job(11'd2, 10'd1);
    n_cmp++; if ({bus.IMapRdEn, bus.IMapRdAddr, bus.WtRdAddr} !== {1'b1, ADDR_W'(0), 11'd0}) begin n_err++; $display("FAIL restart_first: en %b addr %0d wt %0d required 1/0/0", bus.IMapRdEn, bus.IMapRdAddr, bus.WtRdAddr); end
    cyc();
    n_cmp++; if ({bus.IMapRdAddr, bus.WtRdAddr} !== {ADDR_W'(1), 11'd1}) begin n_err++; $display("FAIL restart_second: addr %0d wt %0d required 1/1", bus.IMapRdAddr, bus.WtRdAddr); end
    bus.Clear = 1'b1; cyc(); bus.Clear = 1'b0;
  endtask

  task automatic test_relu();
    logic [15:0] v, e;
    int m;
    start_job(11'd1, 10'd1);
    for (int j = 0; j <= 10; j++) begin
      if (j >= 1) begin
        m = j - 1;
        if (m < 8) begin
          v = (m == 0) ? 16'hFFF0 : (m == 2) ? 16'h8000 : 16'(16'h0100 + m);
`ifdef PE_CTRL_RELU_EN
          e = v[15] ? 16'h0000 : v;
`else
          e = v;
`endif
          n_cmp++; if ({bus.ResWrEn, bus.ResWrAddr} !== {1'b1, ADDR_W'(m)}) begin n_err++; $display("FAIL relu_wr[%0d]: en %b addr %0d required 1/%0d", m, bus.ResWrEn, bus.ResWrAddr, m); end
          n_cmp++; if (bus.ResWrData !== e) begin n_err++; $display("FAIL relu_data[%0d]: got %h required %h", m, bus.ResWrData, e); end
        end else begin
          n_cmp++; if (bus.ResWrEn !== 1'b0) begin n_err++; $display("FAIL relu_excess[%0d]: got %b required 0", m, bus.ResWrEn); end
        end
        n_cmp++; if (bus.Done !== (j == 9)) begin n_err++; $display("FAIL relu_done[%0d]: got %b required %b", j, bus.Done, (j == 9)); end
      end
      d_vld  = (j < 10);
      d_omap = (j == 0) ? 16'hFFF0 : (j == 2) ? 16'h8000 : 16'(16'h0100 + j);
      cyc();
    end
    d_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_job(11'd4, 10'd4);
    cyc(); cyc();
    n_cmp++; if (bus.IMapRdEn !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %b required 1", bus.IMapRdEn); end
    #1 rst_cal_n = 1'b0;
    #1;
    n_cmp++; if ({bus.IMapRdEn, bus.Busy, bus.PE_IMapVld} !== 3'b000) begin n_err++; $display("FAIL rstmid_flags: got %b required 000", {bus.IMapRdEn, bus.Busy, bus.PE_IMapVld}); end
    n_cmp++; if ({bus.PE_WeightVld, bus.IMapRdAddr, bus.PE_Calcycle} !== '0) begin n_err++; $display("FAIL rstmid_regs: wvld %h addr %0d cal %0d required 0", bus.PE_WeightVld, bus.IMapRdAddr, bus.PE_Calcycle); end
    cyc();
    rst_cal_n = 1'b1;
    cyc();
    n_cmp++; if ({bus.Busy, bus.IMapRdEn} !== 2'b00) begin n_err++; $display("FAIL rstmid_after: got %b required 00", {bus.Busy, bus.IMapRdEn}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.Start = 1'b0; bus.Clear = 1'b0; bus.Calcycle = '0; bus.OutLen = '0;
    bus.IMapRdData = '0; bus.WtRdData = '0;
    model_en = 1'b0; d_vld = 1'b0; d_omap = '0; m_cal = '0;
    rst_cal_n = 1'b0;
    test_reset();
    test_addr_seq();
    test_model();
    test_zero_len();
    test_clear();
    test_relu();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
